// File: rtl/traffic_intersection_model.sv
// Street-side plant model for the traffic light controller: per-lane car queues,
// green-only departures, and sticky light-conflict monitoring.
package light_package;
    typedef enum logic [1:0] {
        red    = 2'b00,
        yellow = 2'b01,
        green  = 2'b10
    } colors;
endpackage

module traffic_intersection_model #(
    parameter int unsigned QDEPTH        = 7,
    parameter int unsigned DEPART_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            arrive,
    input  light_package::colors  e_str_light,
    input  light_package::colors  e_left_light,
    input  light_package::colors  w_str_light,
    input  light_package::colors  w_left_light,
    input  light_package::colors  ns_light,
    output logic                  e_straight_sensor,
    output logic                  e_left_sensor,
    output logic                  w_straight_sensor,
    output logic                  w_left_sensor,
    output logic                  ns_sensor,
    output logic [4:0]            depart,
    output logic [19:0]           q_count,
    output logic [15:0]           total_departed,
    output logic [4:0]            overflow,
    output logic                  conflict,
    output logic [7:0]            conflict_count
);

    localparam int unsigned LANES = 5;
    localparam int unsigned CW    = 4;
    localparam int unsigned TW    = 4;

    logic [CW-1:0]    r_count [LANES];
    logic [TW-1:0]    r_timer [LANES];
    logic [LANES-1:0] r_depart;
    logic [LANES-1:0] r_overflow;
    logic [15:0]      r_total;
    logic             r_conflict;
    logic [7:0]       r_conflict_count;

    logic [1:0]       w_light     [LANES];
    logic [CW-1:0]    w_count_nxt [LANES];
    logic [TW-1:0]    w_timer_nxt [LANES];
    logic [LANES-1:0] w_active;
    logic [LANES-1:0] w_invalid;
    logic [LANES-1:0] w_drain;
    logic [LANES-1:0] w_leave;
    logic [LANES-1:0] w_accept;
    logic [LANES-1:0] w_drop;
    logic [2:0]       w_leave_cnt;
    logic             w_conflict;

    assign w_light[0] = e_str_light;
    assign w_light[1] = e_left_light;
    assign w_light[2] = w_str_light;
    assign w_light[3] = w_left_light;
    assign w_light[4] = ns_light;

    // Per-lane queue/timer next state; a departure frees a slot for a same-edge arrival
    always_comb begin
        w_active    = '0;
        w_invalid   = '0;
        w_drain     = '0;
        w_leave     = '0;
        w_accept    = '0;
        w_drop      = '0;
        w_leave_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_count_nxt[i] = r_count[i];
            w_timer_nxt[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            w_active[i]    = (w_light[i] != 2'b00);
            w_invalid[i]   = (w_light[i] == 2'b11);
            w_drain[i]     = (w_light[i] == 2'b10) && (r_count[i] != '0);
            w_leave[i]     = w_drain[i] && (r_timer[i] == TW'(DEPART_CYCLES - 1));
            w_accept[i]    = arrive[i] && ((r_count[i] < CW'(QDEPTH)) || w_leave[i]);
            w_drop[i]      = arrive[i] && !w_accept[i];
            w_count_nxt[i] = r_count[i] + CW'(w_accept[i]) - CW'(w_leave[i]);
            w_timer_nxt[i] = (w_drain[i] && !w_leave[i]) ? r_timer[i] + TW'(1) : '0;
            w_leave_cnt    = w_leave_cnt + 3'(w_leave[i]);
        end
    end

    assign w_conflict = (w_active[1] && (w_active[2] || w_active[4]))
                     || (w_active[3] && (w_active[0] || w_active[4]))
                     || (w_active[4] && (w_active[0] || w_active[2]))
                     || (|w_invalid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                r_count[i] <= '0;
                r_timer[i] <= '0;
            end
            r_depart         <= '0;
            r_overflow       <= '0;
            r_total          <= '0;
            r_conflict       <= 1'b0;
            r_conflict_count <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_count[i] <= w_count_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
            r_depart   <= w_leave;
            r_overflow <= r_overflow | w_drop;
            r_total    <= r_total + 16'(w_leave_cnt);
            if (w_conflict) begin
                r_conflict <= 1'b1;
                if (r_conflict_count != 8'hFF) begin
                    r_conflict_count <= r_conflict_count + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_qpack
        assign q_count[4*g +: 4] = r_count[g];
    end

    assign e_straight_sensor = (r_count[0] != '0);
    assign e_left_sensor     = (r_count[1] != '0);
    assign w_straight_sensor = (r_count[2] != '0);
    assign w_left_sensor     = (r_count[3] != '0);
    assign ns_sensor         = (r_count[4] != '0);
    assign depart            = r_depart;
    assign total_departed    = r_total;
    assign overflow          = r_overflow;
    assign conflict          = r_conflict;
    assign conflict_count    = r_conflict_count;

endmodule

// File: tb/tb_traffic_intersection_model.sv
// Scenario and randomized checks of traffic_intersection_model against a
// queue-level reference model of the intersection.
module tb_traffic_intersection_model;
    import light_package::*;

    localparam int Q = 7;
    localparam int D = 2;
    localparam logic [1:0] LR = 2'b00;
    localparam logic [1:0] LY = 2'b01;
    localparam logic [1:0] LG = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  arrive;
    colors       e_str_l, e_left_l, w_str_l, w_left_l, ns_l;
    logic        s_es, s_el, s_ws, s_wl, s_ns;
    logic [4:0]  depart;
    logic [19:0] q_count;
    logic [15:0] total_departed;
    logic [4:0]  overflow;
    logic        conflict;
    logic [7:0]  conflict_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         m_cnt [5];
    int         m_prog [5];
    int         m_total;
    int         m_cc;
    logic [4:0] m_ovf;
    logic [4:0] m_dep;
    bit         m_conf;

    traffic_intersection_model #(.QDEPTH(Q), .DEPART_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .arrive(arrive),
        .e_str_light(e_str_l), .e_left_light(e_left_l), .w_str_light(w_str_l),
        .w_left_light(w_left_l), .ns_light(ns_l),
        .e_straight_sensor(s_es), .e_left_sensor(s_el), .w_straight_sensor(s_ws),
        .w_left_sensor(s_wl), .ns_sensor(s_ns),
        .depart(depart), .q_count(q_count), .total_departed(total_departed),
        .overflow(overflow), .conflict(conflict), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] lights(input logic [1:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic bit is_conflict(input logic [9:0] lts);
        int pa [6] = '{1, 1, 3, 3, 4, 4};
        int pb [6] = '{2, 4, 0, 4, 0, 2};
        bit act [5];
        bit bad = 0;
        for (int i = 0; i < 5; i++) begin
            act[i] = (lts[2*i +: 2] != 2'b00);
            if (lts[2*i +: 2] == 2'b11) bad = 1;
        end
        for (int k = 0; k < 6; k++) if (act[pa[k]] && act[pb[k]]) bad = 1;
        return bad;
    endfunction

    function automatic logic [19:0] m_q();
        logic [19:0] r = '0;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'(m_cnt[i]);
        return r;
    endfunction

    function automatic logic [4:0] m_sens();
        logic [4:0] r = '0;
        for (int i = 0; i < 5; i++) r[i] = (m_cnt[i] != 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_cnt[i]  = 0;
            m_prog[i] = 0;
        end
        m_total = 0; m_cc = 0; m_ovf = '0; m_dep = '0; m_conf = 0;
    endtask

    // One clock edge of the intersection: cars leave on every D-th green edge, then arrivals queue
    task automatic model_step(input logic [4:0] arr, input logic [9:0] lts);
        int n = 0;
        m_dep = '0;
        for (int i = 0; i < 5; i++) begin
            if (lts[2*i +: 2] == LG && m_cnt[i] > 0) begin
                m_prog[i] = (m_prog[i] + 1) % D;
                if (m_prog[i] == 0) begin
                    m_cnt[i]--;
                    m_dep[i] = 1'b1;
                    n++;
                end
            end else begin
                m_prog[i] = 0;
            end
            if (arr[i]) begin
                if (m_cnt[i] < Q) m_cnt[i]++;
                else m_ovf[i] = 1'b1;
            end
        end
        m_total = (m_total + n) % 65536;
        if (is_conflict(lts)) begin
            m_conf = 1;
            if (m_cc < 255) m_cc++;
        end
    endtask

    // Drive one cycle from a negedge, advance the model, and return at the next negedge
    task automatic cycle(input logic [4:0] arr, input logic [9:0] lts);
        arrive   = arr;
        e_str_l  = colors'(lts[1:0]);
        e_left_l = colors'(lts[3:2]);
        w_str_l  = colors'(lts[5:4]);
        w_left_l = colors'(lts[7:6]);
        ns_l     = colors'(lts[9:8]);
        @(posedge clk);
        model_step(arr, lts);
        @(negedge clk);
        arrive = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arrive = '0;
        e_str_l = red; e_left_l = red; w_str_l = red; w_left_l = red; ns_l = red;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [9:0] all_g;
        all_g = lights(LG, LG, LG, LG, LG);
        apply_reset();
        checks++;
        if ({q_count, depart, overflow, total_departed, conflict, conflict_count} !== '0) begin
            failures++;
            $display("FAIL reset_state q=%h dep=%b ovf=%b tot=%0d conf=%b cc=%0d exp all zero",
                     q_count, depart, overflow, total_departed, conflict, conflict_count);
        end
        for (int k = 0; k < 3; k++) cycle(5'b00010, '0);
        cycle('0, all_g);
        checks++;
        if (q_count[7:4] !== 4'd3 || conflict !== 1'b1) begin
            failures++;
            $display("FAIL reset_preload lane1=%0d conf=%b exp 3,1", q_count[7:4], conflict);
        end
        arrive = 5'b00010;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({q_count, depart, total_departed, conflict, conflict_count} !== '0 ||
            {s_es, s_el, s_ws, s_wl, s_ns} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset q=%h dep=%b tot=%0d conf=%b cc=%0d sens=%b exp zero",
                     q_count, depart, total_departed, conflict, conflict_count,
                     {s_ns, s_wl, s_ws, s_el, s_es});
        end
        @(negedge clk);
        arrive = '0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_drain();
        int exp_q [6] = '{3, 2, 2, 1, 1, 0};
        int pulses = 0;
        apply_reset();
        for (int k = 0; k < 3; k++) cycle(5'b00010, '0);
        checks++;
        if (q_count[7:4] !== 4'd3 || s_el !== 1'b1) begin
            failures++;
            $display("FAIL drain_load lane1=%0d sens=%b exp 3,1", q_count[7:4], s_el);
        end
        for (int k = 0; k < 6; k++) begin
            cycle('0, lights(LR, LG, LR, LR, LR));
            if (depart[1]) pulses++;
            checks++;
            if (q_count[7:4] !== 4'(exp_q[k])) begin
                failures++;
                $display("FAIL drain_edge%0d lane1=%0d exp %0d", k + 1, q_count[7:4], exp_q[k]);
            end
        end
        checks++;
        if (pulses != 3 || total_departed !== 16'd3 || s_el !== 1'b0) begin
            failures++;
            $display("FAIL drain_done pulses=%0d tot=%0d sens=%b exp 3,3,0",
                     pulses, total_departed, s_el);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 0; k < 8; k++) cycle(5'b10000, '0);
        checks++;
        if (q_count[19:16] !== 4'd7 || overflow !== 5'b10000 || s_ns !== 1'b1) begin
            failures++;
            $display("FAIL overflow lane4=%0d ovf=%b sens=%b exp 7,10000,1",
                     q_count[19:16], overflow, s_ns);
        end
    endtask

    task automatic test_full_depart();
        apply_reset();
        for (int k = 0; k < 7; k++) cycle(5'b00001, '0);
        cycle('0, lights(LG, LR, LR, LR, LR));
        cycle(5'b00001, lights(LG, LR, LR, LR, LR));
        checks++;
        if (q_count[3:0] !== 4'd7 || depart[0] !== 1'b1 || overflow[0] !== 1'b0) begin
            failures++;
            $display("FAIL full_depart lane0=%0d dep0=%b ovf0=%b exp 7,1,0",
                     q_count[3:0], depart[0], overflow[0]);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        for (int k = 0; k < 3; k++) cycle('0, lights(LY, LR, LR, LR, LG));
        checks++;
        if (conflict !== 1'b1 || conflict_count !== 8'd3) begin
            failures++;
            $display("FAIL conflict_set conf=%b cc=%0d exp 1,3", conflict, conflict_count);
        end
        for (int k = 0; k < 2; k++) cycle('0, '0);
        for (int k = 0; k < 3; k++) cycle('0, lights(LG, LR, LG, LR, LR));
        checks++;
        if (conflict !== 1'b1 || conflict_count !== 8'd3) begin
            failures++;
            $display("FAIL conflict_hold conf=%b cc=%0d exp 1,3", conflict, conflict_count);
        end
        for (int k = 0; k < 2; k++) cycle('0, lights(LR, LG, LR, LG, LR));
        checks++;
        if (conflict_count !== 8'd3) begin
            failures++;
            $display("FAIL conflict_lefts cc=%0d exp 3", conflict_count);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int k = 0; k < 260; k++) cycle('0, lights(2'b11, LR, LR, LR, LR));
        checks++;
        if (conflict !== 1'b1 || conflict_count !== 8'd255) begin
            failures++;
            $display("FAIL saturate conf=%b cc=%0d exp 1,255", conflict, conflict_count);
        end
    endtask

    task automatic test_closed_loop();
        apply_reset();
        cycle(5'b11111, '0);
        cycle(5'b11111, '0);
        for (int k = 0; k < 4; k++) cycle('0, lights(LG, LR, LG, LR, LR));
        cycle('0, lights(LY, LR, LY, LR, LR));
        cycle('0, '0);
        for (int k = 0; k < 4; k++) cycle('0, lights(LR, LG, LR, LG, LR));
        cycle('0, lights(LR, LY, LR, LY, LR));
        cycle('0, '0);
        for (int k = 0; k < 4; k++) cycle('0, lights(LR, LR, LR, LR, LG));
        checks++;
        if (q_count !== '0 || total_departed !== 16'd10 || conflict !== 1'b0 || overflow !== '0) begin
            failures++;
            $display("FAIL closed_loop q=%h tot=%0d conf=%b ovf=%b exp 0,10,0,0",
                     q_count, total_departed, conflict, overflow);
        end
    endtask

    task automatic test_random();
        logic [4:0] arr;
        logic [9:0] lts;
        logic [1:0] c;
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            arr = 5'($urandom & $urandom);
            c = ($urandom_range(0, 3) == 0) ? LY : LG;
            case ($urandom_range(0, 9))
                0, 1, 2: lts = lights(c, LR, c, LR, LR);
                3, 4, 5: lts = lights(LR, c, LR, c, LR);
                6, 7:    lts = lights(LR, LR, LR, LR, c);
                8:       lts = '0;
                default: lts = 10'($urandom);
            endcase
            cycle(arr, lts);
            checks++;
            if (q_count !== m_q() || depart !== m_dep || overflow !== m_ovf ||
                total_departed !== 16'(m_total) || conflict !== m_conf ||
                conflict_count !== 8'(m_cc) || {s_ns, s_wl, s_ws, s_el, s_es} !== m_sens()) begin
                failures++;
                $display("FAIL random_cyc%0d q=%h/%h dep=%b/%b ovf=%b/%b tot=%0d/%0d conf=%b/%b cc=%0d/%0d",
                         k, q_count, m_q(), depart, m_dep, overflow, m_ovf, total_departed,
                         m_total, conflict, m_conf, conflict_count, m_cc);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        arrive = '0;
        e_str_l = red; e_left_l = red; w_str_l = red; w_left_l = red; ns_l = red;
        model_reset();
        test_reset();
        test_drain();
        test_overflow();
        test_full_depart();
        test_conflict();
        test_saturate();
        test_closed_loop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
